mandelbrot_pixel_sink: RTL and testbench
========================================

# mandelbrot_pixel_sink

Consumer-side controller for the `mandelbrot` engine's per-pixel `run`/`running` handshake. Issues one `run` pulse per pixel, captures the 4-bit `ctr_out` when each pixel completes, and packs two pixels per byte into a small FIFO. Streams bytes out on a valid/ready interface with a frame-last marker. Sits between the engine and the output path (SPI/UART/VGA serializer), and throttles the engine whenever the downstream stalls.

## Interface
- `WIDTH`, 320: pixels per line; must match the engine.
- `HEIGHT`, 240: lines per frame; must match the engine.
- `FIFO_DEPTH`, 4: byte FIFO entries; power of two, ≥2.
- `clk` in 1: single clock for the block.
- `rst_n` in 1: asynchronous, active-low reset.
- `start` in 1: one-cycle request to render and stream one frame; ignored while `busy`.
- `busy` out 1: high from accepted `start` until the last byte is popped.
- `run` out 1: one-cycle pulse to the engine, requesting the next pixel.
- `running` in 1: engine busy with a pixel.
- `finished` in 1: engine frame-complete flag.
- `ctr_out` in 4: engine result; valid once `running` falls.
- `out_data` out 8: packed byte, {odd pixel[3:0], even pixel[3:0]}.
- `out_valid` out 1: byte available.
- `out_ready` in 1: downstream accepts the byte.
- `out_last` out 1: qualifies the final byte of the frame.
- `frame_done` out 1: one-cycle pulse when the last byte is accepted.
- `sync_err` out 1: sticky frame/engine mismatch flag; cleared by accepted `start`.

## Operation
- FSM states: IDLE, ISSUE, WAIT_HI, WAIT_LO, DRAIN.
- **IDLE:** on `start`:
  - clear pixel counter `pix`, nibble-hold flag `half`, and `sync_err`;
  - go to ISSUE.
- **ISSUE:** when FIFO count < `FIFO_DEPTH`, assert `run` for exactly this cycle, then go to WAIT_HI. Otherwise hold, with `run` low.
- **WAIT_HI:** wait for `running`=1, then go to WAIT_LO.
- **WAIT_LO:** in the first cycle with `running`=0, capture `ctr_out` and increment `pix`.
  - If `half`=0: store the nibble in the hold register and set `half`=1.
  - If `half`=1: push {`ctr_out`, hold} and clear `half`.
- **Frame end:** occurs when the captured `finished`=1 or the incremented `pix` = WIDTH·HEIGHT.
  - The push carries last=1.
  - If `half` was 0, push {4'h0, `ctr_out`} with last=1 instead of holding.
  - Go to DRAIN.
  - Otherwise, go back to ISSUE.
- **sync_err:** set at frame end if `finished` ≠ (`pix`+1 = WIDTH·HEIGHT).
- **DRAIN:** wait for the last-marked byte to be popped, then pulse `frame_done`, drop `busy`, and go to IDLE.
- **Flow control:** at most one pixel is in flight, so the ISSUE check (count < DEPTH) guarantees every push has room. The FIFO never overflows, and pushes are never dropped.
- **Simultaneous push and pop:** count is unchanged and both complete.
- **Reset mid-frame:** FSM to IDLE and FIFO emptied. The engine shares `rst_n` and restarts from its own reset.
- `start` outside IDLE is ignored.

## Timing
- Reset values:
  - `run`=0, `busy`=0, `out_valid`=0, `out_last`=0, `out_data`=0;
  - `frame_done`=0, `sync_err`=0;
  - internal state IDLE, `pix`=0, `half`=0.
- `start` at edge N → `busy`=1 after N; `run`=1 in cycle N+1 (FIFO empty).
- Engine `running` rises the cycle after `run`.
- Capture occurs at the first edge that samples `running`=0, one cycle after the engine's completion edge.
- A push at edge M gives `out_valid`=1 after M when the FIFO was empty. FIFO output is show-ahead.
- Pixel-to-pixel overhead is 3 cycles plus ALU time: run, WAIT_HI, WAIT_LO capture. The next `run` comes in the cycle after capture.
- `frame_done` is asserted in the cycle after the edge where the last byte is popped.

## Structure
- **Shared package** (`mandelbrot_pkg`):
  - pixel-count width `$clog2(WIDTH*HEIGHT+1)`;
  - FSM state encoding;
  - nibble pad constant 4'h0.
- **Sub-module** `mandelbrot_byte_fifo`:
  - 9-bit entries (data + last), `FIFO_DEPTH` deep, show-ahead;
  - `count` output;
  - async active-low reset on pointers and count.

## Test plan
Parameters WIDTH=4, HEIGHT=2, behavioural engine model with 5-cycle ALU, `out_ready`=1.
- `start` pulse, model returns ctr 1..8 → bytes 0x21, 0x43, 0x65, 0x87; `out_last` only on 0x87; one `frame_done`; `sync_err`=0.
- `out_ready`=0 for the whole frame, FIFO_DEPTH=2 → exactly 4 pixels run, `run` stays low; release → remaining 4 pixels complete and order is preserved.
- Model asserts `finished` on pixel 5 → bytes 0x21, 0x43, then 0x05 with last=1; `sync_err`=1.
- Model never asserts `finished` → 4 bytes end at `pix`=8 with last=1; `sync_err`=1.
- `rst_n` low during pixel 3 → all outputs return to reset values; a new `start` yields the full 4-byte frame.
- `start` while `busy`=1 → ignored; byte count stays 4.

Source files
------------

// File: rtl/mandelbrot_pkg.sv
// Shared definitions for the mandelbrot pixel sink: FSM encoding, padding nibble
// and pixel-counter sizing.
package mandelbrot_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    WAIT_HI,
    WAIT_LO,
    DRAIN
  } sink_state_t;

  localparam logic [3:0] NIBBLE_PAD = 4'h0;

  // Counter must hold WIDTH*HEIGHT itself, not just the last index.
  function automatic int pix_count_width(input int w, input int h);
    return $clog2(w * h + 1);
  endfunction

endpackage

// File: rtl/mandelbrot_pixel_sink_if.sv
// Packed-byte output stream of the pixel sink (valid/ready with frame-last marker).
interface mandelbrot_pixel_sink_if;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_ready;
  logic       out_last;

  modport master (output out_data, output out_valid, output out_last, input out_ready);
  modport slave  (input out_data, input out_valid, input out_last, output out_ready);
endinterface

// File: rtl/mandelbrot_byte_fifo.sv
// Small show-ahead FIFO of {last, byte} entries with an occupancy count.
module mandelbrot_byte_fifo #(
  parameter  int DEPTH = 4,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [8:0]       push_data,
  input  logic             pop,
  output logic [8:0]       head,
  output logic [CNT_W-1:0] count
);

  localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

  logic [8:0]       mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign do_pop  = pop && (count != '0);
  assign do_push = push && ((count != FULL) || do_pop);
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  // DEPTH is a power of two, so the pointers wrap naturally.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/mandelbrot_pixel_sink.sv
// Drives the engine one pixel at a time, packs two 4-bit results per byte and
// streams the bytes out, stalling the engine while the byte FIFO is full.
module mandelbrot_pixel_sink
  import mandelbrot_pkg::*;
#(
  parameter int WIDTH      = 320,
  parameter int HEIGHT     = 240,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           start,
  output logic                           busy,
  output logic                           run,
  input  logic                           running,
  input  logic                           finished,
  input  logic [3:0]                     ctr_out,
  mandelbrot_pixel_sink_if.master        out_if,
  output logic                           frame_done,
  output logic                           sync_err
);

  localparam int               PIX_W     = pix_count_width(WIDTH, HEIGHT);
  localparam logic [PIX_W-1:0] PIX_TOTAL = PIX_W'(WIDTH * HEIGHT);
  localparam int               CNT_W     = $clog2(FIFO_DEPTH + 1);
  localparam logic [CNT_W-1:0] FIFO_FULL = CNT_W'(FIFO_DEPTH);

  sink_state_t      state, state_nxt;
  logic [PIX_W-1:0] pix, pix_inc;
  logic             half;
  logic [3:0]       hold;
  logic             push;
  logic [8:0]       push_data;
  logic [8:0]       head;
  logic [CNT_W-1:0] count;
  logic             pop;
  logic             last_pop;
  logic             captured;
  logic             frame_end;

  assign pix_inc   = pix + 1'b1;
  assign captured  = (state == WAIT_LO) && !running;
  assign frame_end = finished || (pix_inc == PIX_TOTAL);
  assign busy      = (state != IDLE);

  // Empty FIFO presents zeros rather than stale (or never-written) memory.
  assign out_if.out_valid = (count != '0);
  assign out_if.out_data  = out_if.out_valid ? head[7:0] : 8'h00;
  assign out_if.out_last  = out_if.out_valid && head[8];
  assign pop              = out_if.out_valid && out_if.out_ready;
  assign last_pop         = pop && head[8];

  mandelbrot_byte_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push),
    .push_data (push_data),
    .pop       (pop),
    .head      (head),
    .count     (count)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Only one pixel is ever in flight, so a free slot at ISSUE guarantees room
  // for whatever push that pixel produces.
  always_comb begin
    state_nxt = state;
    run       = 1'b0;
    push      = 1'b0;
    push_data = '0;
    case (state)
      IDLE:    if (start) state_nxt = ISSUE;
      ISSUE: begin
        if (count < FIFO_FULL) begin
          run       = 1'b1;
          state_nxt = WAIT_HI;
        end
      end
      WAIT_HI: if (running) state_nxt = WAIT_LO;
      WAIT_LO: begin
        if (!running) begin
          if (half) begin
            push      = 1'b1;
            push_data = {frame_end, ctr_out, hold};
          end else if (frame_end) begin
            push      = 1'b1;
            push_data = {1'b1, NIBBLE_PAD, ctr_out};
          end
          state_nxt = frame_end ? DRAIN : ISSUE;
        end
      end
      DRAIN:   if (last_pop) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pix        <= '0;
      half       <= 1'b0;
      hold       <= 4'h0;
      sync_err   <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= (state == DRAIN) && last_pop;
      if ((state == IDLE) && start) begin
        pix      <= '0;
        half     <= 1'b0;
        sync_err <= 1'b0;
      end else if (captured) begin
        pix <= pix_inc;
        if (half) begin
          half <= 1'b0;
        end else if (!frame_end) begin
          hold <= ctr_out;
          half <= 1'b1;
        end
        if (frame_end) sync_err <= (finished != (pix_inc == PIX_TOTAL));
      end
    end
  end

endmodule

// File: tb/tb_mandelbrot_pixel_sink.sv
// Directed bench for mandelbrot_pixel_sink on a 4x2 frame with a behavioural engine.
module tb_mandelbrot_pixel_sink;

  localparam int W     = 4;
  localparam int H     = 2;
  localparam int DEPTH = 2;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       busy, run, frame_done, sync_err;
  logic       running, finished;
  logic [3:0] ctr_out;

  logic       eng_clear = 1'b0;
  int         finish_at = 8;
  logic [2:0] alu;
  int         eng_idx;

  logic [7:0] byte_q[$];
  logic       last_q[$];
  int         run_cnt = 0;
  int         done_cnt = 0;

  int checks = 0;
  int errors = 0;

  mandelbrot_pixel_sink_if sink_if ();

  mandelbrot_pixel_sink #(.WIDTH(W), .HEIGHT(H), .FIFO_DEPTH(DEPTH)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .busy       (busy),
    .run        (run),
    .running    (running),
    .finished   (finished),
    .ctr_out    (ctr_out),
    .out_if     (sink_if),
    .frame_done (frame_done),
    .sync_err   (sync_err)
  );

  always #5 clk = ~clk;

  // Engine: running rises after run, falls after a 5-cycle ALU with the result.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      running  <= 1'b0;
      finished <= 1'b0;
      ctr_out  <= 4'h0;
      alu      <= 3'd0;
      eng_idx  <= 0;
    end else if (eng_clear) begin
      eng_idx  <= 0;
      finished <= 1'b0;
    end else if (run) begin
      running  <= 1'b1;
      finished <= 1'b0;
      alu      <= 3'd5;
    end else if (running) begin
      alu <= alu - 3'd1;
      if (alu == 3'd1) begin
        running  <= 1'b0;
        ctr_out  <= 4'(eng_idx + 1);
        finished <= ((eng_idx + 1) == finish_at);
        eng_idx  <= eng_idx + 1;
      end
    end
  end

  always @(negedge clk) begin
    if (sink_if.out_valid && sink_if.out_ready) begin
      byte_q.push_back(sink_if.out_data);
      last_q.push_back(sink_if.out_last);
    end
    if (run)        run_cnt  <= run_cnt + 1;
    if (frame_done) done_cnt <= done_cnt + 1;
  end

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic apply_stimulus(input logic clear_engine);
    start     = 1'b1;
    eng_clear = clear_engine;
    tick(1);
    start     = 1'b0;
    eng_clear = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int target);
    for (int i = 0; i < 600 && done_cnt < target; i++) tick(1);
    check_output({tag, " frame_done count"}, 32'(done_cnt), 32'(target));
  endtask

  task automatic check_frame(input string tag, input int base, input int n, input logic [31:0] exp_bytes);
    check_output({tag, " byte count"}, 32'(byte_q.size() - base), 32'(n));
    if (byte_q.size() == base + n) begin
      for (int i = 0; i < n; i++) begin
        check_output($sformatf("%s byte%0d", tag, i), 32'(byte_q[base + i]), 32'(exp_bytes[8*i +: 8]));
        check_output($sformatf("%s last%0d", tag, i), 32'(last_q[base + i]), 32'(i == n - 1));
      end
    end
  endtask

  task automatic check_reset_values(input string tag);
    check_output({tag, " run"},        32'(run), 32'd0);
    check_output({tag, " busy"},       32'(busy), 32'd0);
    check_output({tag, " out_valid"},  32'(sink_if.out_valid), 32'd0);
    check_output({tag, " out_last"},   32'(sink_if.out_last), 32'd0);
    check_output({tag, " out_data"},   32'(sink_if.out_data), 32'd0);
    check_output({tag, " frame_done"}, 32'(frame_done), 32'd0);
    check_output({tag, " sync_err"},   32'(sync_err), 32'd0);
  endtask

  initial begin
    int base_b, base_r, base_d;
    sink_if.out_ready = 1'b1;

    $display("[TB] reset");
    rst_n = 1'b0;
    tick(2);
    check_reset_values("reset");
    rst_n = 1'b1;
    tick(2);

    $display("[TB] normal frame");
    finish_at = 8;
    base_b = byte_q.size(); base_r = run_cnt; base_d = done_cnt;
    apply_stimulus(1'b1);
    check_output("start busy", 32'(busy), 32'd1);
    check_output("start run",  32'(run), 32'd1);
    wait_done("normal", base_d + 1);
    check_frame("normal", base_b, 4, 32'h8765_4321);
    check_output("normal runs",     32'(run_cnt - base_r), 32'd8);
    check_output("normal sync_err", 32'(sync_err), 32'd0);
    check_output("normal busy",     32'(busy), 32'd0);

    $display("[TB] downstream stall");
    sink_if.out_ready = 1'b0;
    base_b = byte_q.size(); base_r = run_cnt; base_d = done_cnt;
    apply_stimulus(1'b1);
    tick(200);
    check_output("stall runs",     32'(run_cnt - base_r), 32'd4);
    check_output("stall run low",  32'(run), 32'd0);
    check_output("stall valid",    32'(sink_if.out_valid), 32'd1);
    check_output("stall head",     32'(sink_if.out_data), 32'h21);
    check_output("stall no bytes", 32'(byte_q.size() - base_b), 32'd0);
    sink_if.out_ready = 1'b1;
    wait_done("stall", base_d + 1);
    check_frame("stall", base_b, 4, 32'h8765_4321);
    check_output("stall total runs", 32'(run_cnt - base_r), 32'd8);

    $display("[TB] early finished");
    finish_at = 5;
    base_b = byte_q.size(); base_r = run_cnt; base_d = done_cnt;
    apply_stimulus(1'b1);
    wait_done("early", base_d + 1);
    check_frame("early", base_b, 3, 32'h0005_4321);
    check_output("early runs",     32'(run_cnt - base_r), 32'd5);
    check_output("early sync_err", 32'(sync_err), 32'd1);

    $display("[TB] finished never raised");
    finish_at = 0;
    base_b = byte_q.size(); base_r = run_cnt; base_d = done_cnt;
    apply_stimulus(1'b1);
    check_output("never sync_err cleared", 32'(sync_err), 32'd0);
    wait_done("never", base_d + 1);
    check_frame("never", base_b, 4, 32'h8765_4321);
    check_output("never sync_err", 32'(sync_err), 32'd1);

    $display("[TB] reset mid-frame");
    finish_at = 8;
    base_r = run_cnt;
    apply_stimulus(1'b1);
    for (int i = 0; i < 200 && (run_cnt - base_r) < 3; i++) tick(1);
    check_output("midreset reached pixel3", 32'(run_cnt - base_r), 32'd3);
    tick(2);
    rst_n = 1'b0;
    #1;
    check_reset_values("midreset");
    tick(2);
    rst_n = 1'b1;
    tick(2);
    base_b = byte_q.size(); base_d = done_cnt;
    apply_stimulus(1'b1);
    wait_done("after reset", base_d + 1);
    check_frame("after reset", base_b, 4, 32'h8765_4321);
    check_output("after reset sync_err", 32'(sync_err), 32'd0);

    $display("[TB] start while busy");
    base_b = byte_q.size(); base_r = run_cnt; base_d = done_cnt;
    apply_stimulus(1'b1);
    tick(10);
    apply_stimulus(1'b0);
    wait_done("busy start", base_d + 1);
    tick(30);
    check_frame("busy start", base_b, 4, 32'h8765_4321);
    check_output("busy start runs",  32'(run_cnt - base_r), 32'd8);
    check_output("busy start dones", 32'(done_cnt - base_d), 32'd1);
    check_output("busy start idle",  32'(busy), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
